// File: rtl/banked_ram_if.sv
// banked_ram_if: per-bank read/write ports of the even/odd banked RAM
interface banked_ram_if;
   logic        ready;
   logic [14:0] read_addr_even, write_addr_even, read_addr_odd, write_addr_odd;
   logic [7:0]  read_data_even, write_data_even, read_data_odd, write_data_odd;
   logic        read_hit_even, write_en_even, read_hit_odd, write_en_odd;
   modport slave (
      input  read_addr_even, write_addr_even, write_data_even, write_en_even,
      input  read_addr_odd, write_addr_odd, write_data_odd, write_en_odd,
      output ready, read_data_even, read_hit_even, read_data_odd, read_hit_odd
   );
   modport master (
      output read_addr_even, write_addr_even, write_data_even, write_en_even,
      output read_addr_odd, write_addr_odd, write_data_odd, write_en_odd,
      input  ready, read_data_even, read_hit_even, read_data_odd, read_hit_odd
   );
endinterface

// File: rtl/banked_ram.sv
// banked_ram: even/odd byte-banked RAM window with clear sweep, hit flags and write-first forwarding
module banked_ram #(
   parameter int          ADDRBITS       = 10,
   parameter logic [16:0] TOP            = 17'h04000,
   parameter bit          CLEAR_ON_RESET = 1'b1,
   parameter logic [7:0]  FILL           = 8'h00
) (
   input logic         clk,
   input logic         reset,
   banked_ram_if.slave bus
);
   localparam int          IW    = ADDRBITS - 1;
   localparam int          DEPTH = 1 << IW;
   localparam logic [16:0] WBASE = (TOP - (17'd1 << ADDRBITS)) >> 1;
   localparam logic [16:0] WEND  = TOP >> 1;
   typedef enum logic {CLEAR, RUN} state_t;
   state_t        r_state;
   logic          r_ready;
   logic [IW-1:0] r_cnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state <= CLEAR_ON_RESET ? CLEAR : RUN;
         r_ready <= 1'b0;
         r_cnt   <= '0;
      end else if (r_state == CLEAR) begin
         r_cnt <= r_cnt + 1'b1;
         if (&r_cnt) begin
            r_state <= RUN;
            r_ready <= 1'b1;
         end
      end else
         r_ready <= 1'b1;
   assign bus.ready = r_ready;
   for (genvar b = 0; b < 2; b++) begin : g_bank
      logic [7:0]    r_mem [DEPTH];
      logic [7:0]    r_data;
      logic          r_hit;
      logic [14:0]   w_ra, w_wa;
      logic [7:0]    w_wd;
      logic          w_we, w_rin, w_win, w_commit;
      logic [IW-1:0] w_ri, w_wi;
      assign w_ra     = b ? bus.read_addr_odd  : bus.read_addr_even;
      assign w_wa     = b ? bus.write_addr_odd : bus.write_addr_even;
      assign w_wd     = b ? bus.write_data_odd : bus.write_data_even;
      assign w_we     = b ? bus.write_en_odd   : bus.write_en_even;
      assign w_rin    = {2'b0, w_ra} >= WBASE && {2'b0, w_ra} < WEND;
      assign w_win    = {2'b0, w_wa} >= WBASE && {2'b0, w_wa} < WEND;
      assign w_ri     = IW'(w_ra - WBASE[14:0]);
      assign w_wi     = IW'(w_wa - WBASE[14:0]);
      // r_ready drops asynchronously on reset, so no external write lands while reset is high
      assign w_commit = r_ready && w_we && w_win;
      always_ff @(posedge clk)
         if (r_state == CLEAR) r_mem[r_cnt] <= FILL;
         else if (w_commit) r_mem[w_wi] <= w_wd;
      always_ff @(posedge clk or posedge reset)
         if (reset) begin
            r_data <= 8'hFF;
            r_hit  <= 1'b0;
         end else begin
            r_hit  <= r_ready && w_rin;
            r_data <= !(r_ready && w_rin) ? 8'hFF : (w_commit && w_wi == w_ri) ? w_wd : r_mem[w_ri];
         end
   end
   assign bus.read_data_even = g_bank[0].r_data;
   assign bus.read_hit_even  = g_bank[0].r_hit;
   assign bus.read_data_odd  = g_bank[1].r_data;
   assign bus.read_hit_odd   = g_bank[1].r_hit;
endmodule

// File: tb/tb_banked_ram.sv
// tb_banked_ram: scoreboard bench for a sweeping instance (a) and a no-sweep full-top instance (b)
module tb_banked_ram;
   logic clk = 1'b0, rst_a = 1'b0, rst_b = 1'b0;
   int   cyc = 0, errors = 0, checks = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   banked_ram_if ba ();
   banked_ram_if bb ();
   banked_ram #(.ADDRBITS(10), .TOP(17'h04000), .CLEAR_ON_RESET(1'b1), .FILL(8'hA5)) dut_a (
      .clk(clk), .reset(rst_a), .bus(ba));
   banked_ram #(.ADDRBITS(10), .TOP(17'h10000), .CLEAR_ON_RESET(1'b0), .FILL(8'h00)) dut_b (
      .clk(clk), .reset(rst_b), .bus(bb));

   // k: 0 ready, 1 data_even, 2 hit_even, 3 data_odd, 4 hit_odd
   typedef struct {
      int          due;
      int          d;
      int          k;
      logic [7:0]  exp;
      logic [95:0] nm;
   } exp_t;
   exp_t q[$];

   function automatic logic [7:0] act(int d, int k);
      if (d == 0)
         case (k)
            0: return {7'b0, ba.ready};
            1: return ba.read_data_even;
            2: return {7'b0, ba.read_hit_even};
            3: return ba.read_data_odd;
            default: return {7'b0, ba.read_hit_odd};
         endcase
      case (k)
         0: return {7'b0, bb.ready};
         1: return bb.read_data_even;
         2: return {7'b0, bb.read_hit_even};
         3: return bb.read_data_odd;
         default: return {7'b0, bb.read_hit_odd};
      endcase
   endfunction

   task automatic chk(int d, int k, logic [7:0] e, logic [95:0] nm);
      logic [7:0] a = act(d, k);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %0s: dut%0d sig%0d got %h expected %h", nm, d, k, a, e);
      end
   endtask

   task automatic expect_at(int due, int d, int k, logic [7:0] e, logic [95:0] nm);
      q.push_back('{due, d, k, e, nm});
   endtask

   task automatic expect_rd(int d, int bank, logic [7:0] data, logic hit, logic [95:0] nm);
      expect_at(cyc + 1, d, 1 + 2 * bank, data, nm);
      expect_at(cyc + 1, d, 2 + 2 * bank, {7'b0, hit}, nm);
   endtask

   task automatic step();
      @(negedge clk);
      ba.write_en_even = 1'b0;
      ba.write_en_odd  = 1'b0;
      bb.write_en_even = 1'b0;
      bb.write_en_odd  = 1'b0;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].due <= cyc) begin
               chk(q[i].d, q[i].k, q[i].exp, q[i].nm);
               q.delete(i);
            end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run still active at %0t, expected finish", $time);
      $fatal(1);
   end

   initial begin
      int c0;
      {ba.read_addr_even, ba.write_addr_even, ba.read_addr_odd, ba.write_addr_odd} = '0;
      {ba.write_data_even, ba.write_data_odd, ba.write_en_even, ba.write_en_odd} = '0;
      {bb.read_addr_even, bb.write_addr_even, bb.read_addr_odd, bb.write_addr_odd} = '0;
      {bb.write_data_even, bb.write_data_odd, bb.write_en_even, bb.write_en_odd} = '0;
      #1;
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk(d, 0, 8'h00, "rst_ready");
         chk(d, 1, 8'hFF, "rst_data_e");
         chk(d, 2, 8'h00, "rst_hit_e");
         chk(d, 3, 8'hFF, "rst_data_o");
         chk(d, 4, 8'h00, "rst_hit_o");
      end
      // sweep from release; a write at sweep edge 3 must be dropped
      ba.read_addr_even = 15'h1E00;
      ba.read_addr_odd  = 15'h1FFF;
      rst_a = 1'b0;
      rst_b = 1'b0;
      c0 = cyc;
      expect_at(c0 + 1, 0, 1, 8'hFF, "clr_data");
      expect_at(c0 + 1, 0, 2, 8'h00, "clr_hit");
      expect_at(c0 + 511, 0, 0, 8'h00, "rdy_early");
      expect_at(c0 + 512, 0, 0, 8'h01, "rdy_sweep");
      expect_at(c0 + 1, 1, 0, 8'h01, "rdy_b");
      repeat (2) @(negedge clk);
      ba.write_addr_even = 15'h1E00; ba.write_data_even = 8'h55; ba.write_en_even = 1'b1;
      ba.write_addr_odd  = 15'h1FFF; ba.write_data_odd  = 8'h55; ba.write_en_odd  = 1'b1;
      step();
      while (cyc < c0 + 512) @(negedge clk);
      expect_rd(0, 0, 8'hA5, 1'b1, "fill_1e00");
      expect_rd(0, 1, 8'hA5, 1'b1, "fill_1fff");
      step();
      ba.read_addr_even = 15'h1FFF; ba.read_addr_odd = 15'h1E00;
      expect_rd(0, 0, 8'hA5, 1'b1, "fill_e_1fff");
      expect_rd(0, 1, 8'hA5, 1'b1, "fill_o_1e00");
      step();
      // window, hit and forwarding
      ba.write_addr_even = 15'h1E05; ba.write_data_even = 8'h3C; ba.write_en_even = 1'b1;
      ba.read_addr_even  = 15'h1E05;
      expect_rd(0, 0, 8'h3C, 1'b1, "fwd_even");
      step();
      ba.read_addr_odd = 15'h1DFF;
      expect_rd(0, 0, 8'h3C, 1'b1, "rd_even");
      expect_rd(0, 1, 8'hFF, 1'b0, "below_o");
      step();
      ba.read_addr_even = 15'h1DFF; ba.read_addr_odd = 15'h2000;
      expect_rd(0, 0, 8'hFF, 1'b0, "below_e");
      expect_rd(0, 1, 8'hFF, 1'b0, "above_o");
      step();
      ba.write_addr_even = 15'h2000; ba.write_data_even = 8'h99; ba.write_en_even = 1'b1;
      ba.read_addr_even  = 15'h1E00;
      expect_rd(0, 0, 8'hA5, 1'b1, "oow_nofwd");
      step();
      expect_rd(0, 0, 8'hA5, 1'b1, "oow_keep");
      step();
      ba.write_addr_odd = 15'h1E10; ba.write_data_odd = 8'h77; ba.write_en_odd = 1'b1;
      ba.read_addr_odd  = 15'h1E10;
      expect_rd(0, 1, 8'h77, 1'b1, "fwd_odd");
      step();
      ba.write_addr_odd = 15'h1E10; ba.write_data_odd = 8'h88; ba.write_en_odd = 1'b1;
      ba.read_addr_odd  = 15'h1E11; ba.read_addr_even = 15'h1E10;
      expect_rd(0, 1, 8'hA5, 1'b1, "old_data");
      expect_rd(0, 0, 8'hA5, 1'b1, "indep_e");
      step();
      ba.read_addr_odd = 15'h1E10;
      expect_rd(0, 1, 8'h88, 1'b1, "wr_odd");
      step();
      ba.write_addr_even = 15'h1F00; ba.write_data_even = 8'h11; ba.write_en_even = 1'b1;
      ba.write_addr_odd  = 15'h1F00; ba.write_data_odd  = 8'h22; ba.write_en_odd  = 1'b1;
      step();
      ba.read_addr_even = 15'h1F00; ba.read_addr_odd = 15'h1F00;
      expect_rd(0, 0, 8'h11, 1'b1, "bank_e");
      expect_rd(0, 1, 8'h22, 1'b1, "bank_o");
      step();
      // async reset in RUN, then again 200 cycles into the sweep
      #2 rst_a = 1'b1;
      #1;
      chk(0, 0, 8'h00, "arst_ready");
      chk(0, 1, 8'hFF, "arst_data_e");
      chk(0, 3, 8'hFF, "arst_data_o");
      chk(0, 2, 8'h00, "arst_hit_e");
      @(negedge clk);
      rst_a = 1'b0;
      c0 = cyc;
      while (cyc < c0 + 200) @(negedge clk);
      rst_a = 1'b1;
      #1;
      chk(0, 0, 8'h00, "swrst_ready");
      chk(0, 1, 8'hFF, "swrst_data");
      @(negedge clk);
      rst_a = 1'b0;
      c0 = cyc;
      expect_at(c0 + 511, 0, 0, 8'h00, "rdy2_early");
      expect_at(c0 + 512, 0, 0, 8'h01, "rdy2_sweep");
      while (cyc < c0 + 512) @(negedge clk);
      ba.read_addr_even = 15'h1E05;
      expect_rd(0, 0, 8'hA5, 1'b1, "resweep_e");
      expect_rd(0, 1, 8'hA5, 1'b1, "resweep_o");
      step();
      // instance b: window [0x7E00, 0x7FFF], contents kept across reset
      bb.write_addr_even = 15'h7FFF; bb.write_data_even = 8'hC3; bb.write_en_even = 1'b1;
      bb.write_addr_odd  = 15'h7E00; bb.write_data_odd  = 8'h5A; bb.write_en_odd  = 1'b1;
      bb.read_addr_even  = 15'h7FFF; bb.read_addr_odd   = 15'h7DFF;
      expect_rd(1, 0, 8'hC3, 1'b1, "b_top_fwd");
      expect_rd(1, 1, 8'hFF, 1'b0, "b_below");
      step();
      bb.read_addr_odd = 15'h7E00;
      expect_rd(1, 0, 8'hC3, 1'b1, "b_top");
      expect_rd(1, 1, 8'h5A, 1'b1, "b_base");
      step();
      #2 rst_b = 1'b1;
      #1;
      chk(1, 0, 8'h00, "b_rst_ready");
      chk(1, 1, 8'hFF, "b_rst_data_e");
      chk(1, 3, 8'hFF, "b_rst_data_o");
      @(negedge clk);
      rst_b = 1'b0;
      expect_at(cyc + 1, 1, 0, 8'h01, "b_rdy_again");
      expect_at(cyc + 1, 1, 1, 8'hFF, "b_notrdy");
      expect_at(cyc + 2, 1, 1, 8'hC3, "b_keep_e");
      expect_at(cyc + 2, 1, 3, 8'h5A, "b_keep_o");
      expect_at(cyc + 2, 1, 4, 8'h01, "b_keep_hit");
      repeat (4) @(negedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: %0d expectations left, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/banked_ram.md
# banked_ram

Parametrised even/odd-banked byte RAM for the F8 memory map, the successor to the fixed 1K–8K window RAM. Two independent byte banks are each addressed by a 15-bit word address; the pair forms a 16-bit byte address whose LSB selects the bank. New behaviour over the earlier RAM:
- configurable window top;
- out-of-range detection with a hit flag;
- same-cycle write-to-read forwarding;
- a post-reset clear sweep with a ready flag.

## Interface
- ADDRBITS, 10, log2 of total RAM bytes; legal range 2..15; each bank holds 2^(ADDRBITS-1) bytes.
- TOP, 17'h04000, exclusive upper byte address of the RAM window; must be even and ≥ 2^ADDRBITS; window is [TOP−2^ADDRBITS, TOP).
- CLEAR_ON_RESET, 1, 1 = sweep FILL into both banks after reset; 0 = no sweep.
- FILL, 8'h00, byte written by the clear sweep.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ready  out  1  high when the RAM accepts writes and returns stored data.
- read_addr_even  in  15  word address, even bank read.
- read_data_even  out  8  registered read data, even bank.
- read_hit_even  out  1  registered; previous-cycle read address was in window and ready was high.
- write_addr_even  in  15  word address, even bank write.
- write_data_even  in  8  write data, even bank.
- write_en_even  in  1  write strobe, even bank.
- read_addr_odd, read_data_odd, read_hit_odd, write_addr_odd, write_data_odd, write_en_odd: same as the even-bank ports, for the odd bank.

## Operation
- Word base WBASE = (TOP − 2^ADDRBITS)/2. A word address A is in window iff WBASE ≤ A < TOP/2.
- Bank index = A − WBASE, truncated to ADDRBITS−1 bits.
- The two banks are fully independent. No port interacts with the other bank.
- FSM states:
  - CLEAR: entered on reset if CLEAR_ON_RESET=1. A (ADDRBITS−1)-bit counter starts at 0 and writes FILL to index counter in both banks each cycle. On the cycle counter = 2^(ADDRBITS−1)−1 the last write happens and the next state is RUN.
  - RUN: entered directly from reset if CLEAR_ON_RESET=0. Terminal until the next reset.
- ready = 1 only in RUN.
- Writes:
  - In RUN, a write commits iff write_en is high and the address is in window.
  - Out-of-range writes are ignored with no aliasing.
  - All external writes are ignored in CLEAR.
- Reads, per bank, sampled at each edge:
  - If not ready: data ← 8'hFF, hit ← 0.
  - Else if out of window: data ← 8'hFF, hit ← 0.
  - Else if a write commits this cycle to the same bank index: data ← write_data (write-first forwarding), hit ← 1.
  - Else: data ← stored byte, hit ← 1.
- Memory contents are not cleared by reset itself. Only the sweep clears them, and only if enabled.

## Timing
- Reset values: ready 0; read_data_even/odd 8'hFF; read_hit_even/odd 0; FSM in CLEAR (or RUN if CLEAR_ON_RESET=0); counter 0.
- Reset asserted mid-sweep or mid-RUN takes effect immediately (async):
  - outputs take their reset values;
  - an in-flight write on that edge does not commit;
  - the sweep restarts from index 0 after release.
- Sweep length is N = 2^(ADDRBITS−1) cycles. With ADDRBITS=10, N=512.
- ready rises after the Nth rising edge following reset release.
- With CLEAR_ON_RESET=0, ready rises after the first rising edge following reset release.
- Read latency is 1 cycle: address at edge k gives data/hit valid after edge k.
- A write at edge k is visible to a read sampled at edge k (forwarding) and at any later edge.
- Simultaneous read and write to different indices in the same bank: the read returns the old data.

## Test plan
- Sweep: ADDRBITS=10, FILL=8'hA5, CLEAR_ON_RESET=1. Release reset and count cycles → ready rises after edge 512. Read word 15'h1E00 and word 15'h1FFF on both banks → 8'hA5, hit=1.
- Window/hit, after ready:
  - write 8'h3C to even word 15'h1E05 (byte 0x3C0A), then read it → 8'h3C, hit=1;
  - read word 15'h1DFF → 8'hFF, hit=0;
  - write to 15'h2000, then read 15'h1E00 → unchanged.
- Forwarding, same edge on the odd bank: write 8'h77 and read word 15'h1E10 → read_data_odd = 8'h77 next cycle. A same-edge read of 15'h1E11 returns its prior value.
- Bank independence: even word 15'h1F00 ← 8'h11 and odd word 15'h1F00 ← 8'h22 on the same edge → reads return 8'h11 and 8'h22.
- Writes ignored in CLEAR: a write of 8'h55 to word 15'h1FFF at cycle 3 of the sweep → after ready, the read returns FILL.
- Reset mid-operation: assert reset at sweep cycle 200 → ready=0 and read_data=8'hFF immediately. After release, ready rises after a full 512 edges. Repeat with CLEAR_ON_RESET=0 and TOP=17'h10000 → ready after 1 edge, stored data retained across reset, window ends at word 15'h7FFF.
